// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects and load-use stall FSM for the pipelined MIPS core
// Optional macro FWD_WB_BYPASS_EN adds the write-back port bypass (Fwd=11).
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] IdExSrc,
  input  logic [NUM_SRC*REG_AW-1:0] IfIdSrc,
  input  logic                      IdExMemRead,
  input  logic [REG_AW-1:0]         IdExRt,
  input  logic                      ExMemWb,
  input  logic [REG_AW-1:0]         ExMemRd,
  input  logic                      MemWbWb,
  input  logic [REG_AW-1:0]         MemWbRd,
`ifdef FWD_WB_BYPASS_EN
  input  logic                      WbWe,
  input  logic [REG_AW-1:0]         WbRd,
`endif
  input  logic                      Flush,
  output logic [2*NUM_SRC-1:0]      Fwd,
  output logic                      Stall,
  output logic                      IdExBubble
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t     state;
  logic [1:0] cnt;
  logic       hz;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (ExMemWb && ExMemRd != '0 && ExMemRd == src)
      sel = 2'b10;
    else if (MemWbWb && MemWbRd != '0 && MemWbRd == src)
      sel = 2'b01;
`ifdef FWD_WB_BYPASS_EN
    else if (WbWe && WbRd != '0 && WbRd == src)
      sel = 2'b11;
`endif
    return sel;
  endfunction

  always_comb begin
    Fwd = '0;
    if (rst_n) begin
      for (int i = 0; i < NUM_SRC; i++)
        Fwd[2*i +: 2] = fwdSel(IdExSrc[i*REG_AW +: REG_AW]);
    end
  end

  // hz depends only on pipeline-register contents, never on Stall
  always_comb begin
    hz = 1'b0;
    if (IdExMemRead && IdExRt != '0) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (IfIdSrc[i*REG_AW +: REG_AW] == IdExRt)
          hz = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hz && LOAD_LAT > 1) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          if (cnt == 2'd0)
            state <= IDLE;
          else
            cnt <= cnt - 2'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  // The first bubble cycle comes straight from hz so the hazard is caught in the same cycle
  always_comb begin
    Stall      = 1'b0;
    IdExBubble = 1'b0;
    if (rst_n) begin
      if (Flush) begin
        IdExBubble = 1'b1;
      end else if (state == STALL || (state == IDLE && hz)) begin
        Stall      = 1'b1;
        IdExBubble = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit (LOAD_LAT 1, 3 and 4 side by side)
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*AW-1:0] IdExSrc, IfIdSrc;
  logic          IdExMemRead;
  logic [AW-1:0] IdExRt, ExMemRd, MemWbRd;
  logic          ExMemWb, MemWbWb, Flush;
`ifdef FWD_WB_BYPASS_EN
  logic          WbWe;
  logic [AW-1:0] WbRd;
`endif
  logic [2*NS-1:0] fwdV [3];
  logic          stallV [3];
  logic          bubV [3];

  int nChecks = 0;
  int nFail   = 0;
  int rem [3];

  always #5 clk = ~clk;

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gDut
      fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(latOf(g))) u (
        .clk(clk), .rst_n(rst_n), .IdExSrc(IdExSrc), .IfIdSrc(IfIdSrc),
        .IdExMemRead(IdExMemRead), .IdExRt(IdExRt),
        .ExMemWb(ExMemWb), .ExMemRd(ExMemRd), .MemWbWb(MemWbWb), .MemWbRd(MemWbRd),
`ifdef FWD_WB_BYPASS_EN
        .WbWe(WbWe), .WbRd(WbRd),
`endif
        .Flush(Flush), .Fwd(fwdV[g]), .Stall(stallV[g]), .IdExBubble(bubV[g])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: priority lookup per operand
  function automatic logic [1:0] expSel(input logic [AW-1:0] s);
    if (ExMemWb && ExMemRd != 0 && ExMemRd == s) return 2'b10;
    if (MemWbWb && MemWbRd != 0 && MemWbRd == s) return 2'b01;
`ifdef FWD_WB_BYPASS_EN
    if (WbWe && WbRd != 0 && WbRd == s) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic logic [2*NS-1:0] expFwd();
    logic [2*NS-1:0] f;
    f = '0;
    if (rst_n)
      for (int i = 0; i < NS; i++) f[2*i +: 2] = expSel(IdExSrc[i*AW +: AW]);
    return f;
  endfunction

  function automatic logic expHz();
    logic h;
    h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (IdExMemRead && IdExRt != 0 && IfIdSrc[i*AW +: AW] == IdExRt) h = 1'b1;
    return h;
  endfunction

  // Model of remaining stall cycles per instance
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || Flush) rem[k] <= 0;
      else if (rem[k] > 0) rem[k] <= rem[k] - 1;
      else if (expHz()) rem[k] <= latOf(k) - 1;
    end
  end

  always @(negedge clk) begin
    logic es, eb;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin es = 0; eb = 0; end
      else if (Flush) begin es = 0; eb = 1; end
      else if (rem[k] > 0 || expHz()) begin es = 1; eb = 1; end
      else begin es = 0; eb = 0; end
      chk($sformatf("model_stall[%0d]", k), 32'(stallV[k]), 32'(es));
      chk($sformatf("model_bubble[%0d]", k), 32'(bubV[k]), 32'(eb));
      chk($sformatf("model_fwd[%0d]", k), 32'(fwdV[k]), 32'(expFwd()));
    end
  end

  task automatic clearAll();
    IdExSrc = '0; IfIdSrc = '0; IdExMemRead = 0; IdExRt = '0;
    ExMemWb = 0; ExMemRd = '0; MemWbWb = 0; MemWbRd = '0; Flush = 0;
`ifdef FWD_WB_BYPASS_EN
    WbWe = 0; WbRd = '0;
`endif
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic loadHazard(input logic [AW-1:0] rt);
    IdExMemRead = 1; IdExRt = rt; IfIdSrc = {5'd8, 5'd0};
  endtask

  task automatic countStalls(input logic [AW-1:0] rt, input int holdCycles, output int cnt [3]);
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    loadHazard(rt);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (stallV[k]) cnt[k]++;
      nextCycle();
      if (c == holdCycles - 1) clearAll();
    end
  endtask

  initial begin
    int cnt [3];
    rst_n = 0;
    clearAll();
    nextCycle(); nextCycle();
    chk("reset_stall", 32'(stallV[2]), 32'd0);
    chk("reset_bubble", 32'(bubV[2]), 32'd0);
    rst_n = 1;
    nextCycle();

    ExMemWb = 1; ExMemRd = 5; MemWbWb = 1; MemWbRd = 5; IdExSrc = {5'd5, 5'd5};
    #2 chk("fwd_exmem_priority", 32'(fwdV[0]), 32'b1010);
    nextCycle();
    ExMemRd = 0; MemWbRd = 0; IdExSrc = '0;
    #2 chk("fwd_r0_never", 32'(fwdV[0]), 32'b0000);
    nextCycle();
    ExMemRd = 3; IdExSrc = {5'd7, 5'd3};
    #2 chk("fwd_op0_exmem", 32'(fwdV[0]), 32'b0010);
    nextCycle();
    ExMemWb = 0;
    #2 chk("fwd_no_stale", 32'(fwdV[0]), 32'b0000);
    nextCycle();
    MemWbRd = 7;
    #2 chk("fwd_op1_memwb", 32'(fwdV[0]), 32'b0100);
    nextCycle();
    clearAll();

    countStalls(5'd8, 1, cnt);
    chk("stall_cycles_lat1", 32'(cnt[0]), 32'd1);
    chk("stall_cycles_lat3", 32'(cnt[1]), 32'd3);
    chk("stall_cycles_lat4", 32'(cnt[2]), 32'd4);
    countStalls(5'd0, 1, cnt);
    chk("no_stall_rt0", 32'(cnt[1]), 32'd0);
    countStalls(5'd8, 2, cnt);
    chk("back_to_back_lat1", 32'(cnt[0]), 32'd2);

    loadHazard(5'd8);
    nextCycle();
    clearAll();
    Flush = 1;
    #2 chk("flush_stall_lat3", 32'(stallV[1]), 32'd0);
    chk("flush_bubble_lat3", 32'(bubV[1]), 32'd1);
    nextCycle();
    Flush = 0;
    #2 chk("after_flush_idle", 32'(stallV[1]), 32'd0);
    nextCycle();

    loadHazard(5'd8);
    Flush = 1;
    #2 chk("flush_beats_hz", 32'(stallV[0]), 32'd0);
    nextCycle();
    clearAll();
    nextCycle();

    loadHazard(5'd8);
    nextCycle();
    clearAll();
    #2 chk("lat4_stalling", 32'(stallV[2]), 32'd1);
    rst_n = 0;
    #1 chk("reset_aborts_stall", 32'(stallV[2]), 32'd0);
    nextCycle();
    rst_n = 1;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stallV[2]) cnt[2]++;
      nextCycle();
    end
    chk("idle_after_reset", 32'(cnt[2]), 32'd0);

`ifdef FWD_WB_BYPASS_EN
    WbWe = 1; WbRd = 9; IdExSrc = {5'd0, 5'd9};
    #2 chk("fwd_wb_bypass", 32'(fwdV[0][1:0]), 32'b11);
    nextCycle();
    MemWbWb = 1; MemWbRd = 9;
    #2 chk("fwd_memwb_over_wb", 32'(fwdV[0][1:0]), 32'b01);
    nextCycle();
`else
    IdExSrc = {5'd0, 5'd9};
    #2 chk("fwd_no_bypass", 32'(fwdV[0]), 32'b0000);
    nextCycle();
`endif
    clearAll();
    nextCycle(); nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined MIPS core.
- Generates per-operand ALU-input forward selects for NUM_SRC source operands in ID/EX, from EX/MEM or MEM/WB.
- Contains a load-use stall FSM with a programmable bubble count; it holds PC and IF/ID and bubbles ID/EX.
- Sits beside the ID/EX register; outputs drive the EX operand muxes and the pipeline-register enables/flushes.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of source operands checked (operand i uses bits [i*REG_AW +: REG_AW])
LOAD_LAT, 1, load-use bubble cycles inserted per hazard, legal 1..4

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
IdExSrc  in  NUM_SRC*REG_AW  source register addresses of instruction in EX
IfIdSrc  in  NUM_SRC*REG_AW  source register addresses of instruction in ID
IdExMemRead  in  1  instruction in EX is a load
IdExRt  in  REG_AW  load destination register in EX
ExMemWb  in  1  EX/MEM writes register file
ExMemRd  in  REG_AW  EX/MEM destination
MemWbWb  in  1  MEM/WB writes register file
MemWbRd  in  REG_AW  MEM/WB destination
Flush  in  1  branch/jump flush from EX, kills ID/IF
Fwd  out  2*NUM_SRC  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 see Optional Feature
Stall  out  1  hold PC and IF/ID this cycle
IdExBubble  out  1  zero control fields entering ID/EX this cycle

Behaviour:
- Fwd (combinational, per operand i):
  - 10 if ExMemWb && ExMemRd!=0 && ExMemRd==src_i.
  - Else 01 if MemWbWb && MemWbRd!=0 && MemWbRd==src_i.
  - Else 00.
  - Fully assigned every evaluation; no latched values. EX/MEM always wins over MEM/WB.
  - Fwd forced to 0 while rst_n low.
- Hazard term: hz = IdExMemRead && IdExRt!=0 && (IdExRt equals any IfIdSrc operand).
- FSM states IDLE, STALL; counter cnt is 2 bits.
  - IDLE, hz=1, Flush=0: Stall=1 and IdExBubble=1 combinationally this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-2. If LOAD_LAT==1, stay IDLE.
  - STALL: Stall=1, IdExBubble=1. If cnt==0, go to IDLE; else cnt decrements.
  - Total consecutive stall cycles per hazard = LOAD_LAT exactly.
  - hz is ignored in STALL; it is re-evaluated in IDLE, so back-to-back dependent loads stall again.
- Flush has priority in any state:
  - Stall=0 and IdExBubble=1 that cycle.
  - Next state IDLE, cnt cleared.
  - Flush in IDLE with hz=1 does not stall.
- Reset (async, rst_n low): state IDLE, cnt 0, Stall 0, IdExBubble 0.
  - Reset asserted mid-stall aborts it immediately.
  - First cycle after release is IDLE.
- No combinational path from Stall back into hz.

Optional Feature:
Macro FWD_WB_BYPASS_EN.
- Defined: adds inputs WbWe (1) and WbRd (REG_AW) for the register-file write port one stage past MEM/WB. Lowest-priority match (WbWe && WbRd!=0 && WbRd==src_i) gives Fwd=11.
- Undefined: ports absent; 11 never produced; a WB-only match gives 00.

Test Plan:
- ExMemWb=1, ExMemRd=5, MemWbWb=1, MemWbRd=5, IdExSrc={5,5}: Fwd=1010 (EX/MEM priority on both operands).
- ExMemWb=1, ExMemRd=0, MemWbWb=1, MemWbRd=0, IdExSrc={0,0}: Fwd=0000. Then ExMemRd=3, src0=3, src1=7 with no EX/MEM match on src1: Fwd=0010. Next cycle ExMemWb=0: Fwd=0000 (no stale select).
- LOAD_LAT=1: IdExMemRead=1, IdExRt=8, IfIdSrc1=8 for one cycle: Stall=1, IdExBubble=1 for exactly 1 cycle, then 0. Repeat with IdExRt=0: no stall.
- LOAD_LAT=3: hazard presented once: Stall high exactly 3 cycles. Flush in cycle 2: Stall drops that cycle with IdExBubble=1, FSM returns to IDLE.
- LOAD_LAT=4: rst_n pulled low in stall cycle 2: Stall=0 immediately. After release with no hazard, Stall stays 0.
- FWD_WB_BYPASS_EN defined: WbWe=1, WbRd=9, src0=9, no other match: Fwd[1:0]=11. Add MemWbRd=9 with MemWbWb=1: Fwd[1:0]=01.
